// File: rtl/counter_74hc193.sv
// Presettable synchronous up/down binary counter with cascadable enables,
// single clock plus direction input, asynchronous master reset.
module counter_74hc193 #(
   parameter int WIDTH = 4
) (
   input  logic             CP,
   input  logic             MR,
   input  logic             PL,
   input  logic [WIDTH-1:0] D,
   input  logic             UD,
   input  logic             CEP,
   input  logic             CET,
   output logic [WIDTH-1:0] Q,
   output logic             TCU,
   output logic             TCD
);

   localparam logic [WIDTH-1:0] QMAX = '1;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   generate
      if (WIDTH < 2) begin : g_width_check
         $error("counter_74hc193: WIDTH must be at least 2");
      end
   endgenerate

   // Modulo-2^WIDTH step; wrap in either direction falls out of the truncation.
   function automatic logic [WIDTH-1:0] count_next(input logic [WIDTH-1:0] q,
                                                   input logic up);
      return up ? (q + ONE) : (q - ONE);
   endfunction

   always_ff @(posedge CP or posedge MR) begin
      if (MR) begin
         Q <= '0;
      end else if (!PL) begin
         Q <= D;
      end else if (CEP && CET) begin
         Q <= count_next(Q, UD);
      end
   end

   // Terminal counts ignore CEP so a paused stage still ripples its carry/borrow.
   assign TCU = CET &  UD & (Q == QMAX);
   assign TCD = CET & ~UD & (Q == '0);

endmodule

// File: tb/tb_counter_74hc193.sv
// Directed-vector bench for counter_74hc193: stimulus pushes expected
// responses into a queue, a negedge monitor pops and compares them.
module tb_counter_74hc193;

   logic       CP = 1'b0;
   logic       MR;
   logic       PL;
   logic [3:0] D;
   logic       UD;
   logic       CEP;
   logic       CET;
   logic [3:0] Q;
   logic       TCU;
   logic       TCD;

   logic       c_pl;
   logic [7:0] c_d;
   logic       c_ud;
   logic       c_cep;
   logic       c_cet;
   logic [3:0] c_q0;
   logic [3:0] c_q1;
   logic       c_tcu0;
   logic       c_tcd0;
   logic       c_tcu1;
   logic       c_tcd1;
   logic       c_cet1;

   always #5 CP = ~CP;

   counter_74hc193 #(.WIDTH(4)) dut (
      .CP(CP), .MR(MR), .PL(PL), .D(D), .UD(UD), .CEP(CEP), .CET(CET),
      .Q(Q), .TCU(TCU), .TCD(TCD)
   );

   // Down-counting cascade: stage 1 trickle enable comes from stage 0 borrow.
   assign c_cet1 = c_tcd0;

   counter_74hc193 #(.WIDTH(4)) cas0 (
      .CP(CP), .MR(MR), .PL(c_pl), .D(c_d[3:0]), .UD(c_ud), .CEP(c_cep), .CET(c_cet),
      .Q(c_q0), .TCU(c_tcu0), .TCD(c_tcd0)
   );

   counter_74hc193 #(.WIDTH(4)) cas1 (
      .CP(CP), .MR(MR), .PL(c_pl), .D(c_d[7:4]), .UD(c_ud), .CEP(c_cep), .CET(c_cet1),
      .Q(c_q1), .TCU(c_tcu1), .TCD(c_tcd1)
   );

   typedef struct {
      string      name;
      bit         casc;
      logic [7:0] q;
      logic       tcu;
      logic       tcd;
   } exp_t;

   exp_t sbq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic push(input string name, input bit casc, input logic [7:0] q,
                       input logic tcu, input logic tcd);
      exp_t e;
      e.name = name;
      e.casc = casc;
      e.q    = q;
      e.tcu  = tcu;
      e.tcd  = tcd;
      sbq.push_back(e);
   endtask

   // Drive the single counter after a negedge, let one rising edge act, queue the result.
   task automatic step(input string name, input logic pl, input logic [3:0] d,
                       input logic ud, input logic cep, input logic cet,
                       input logic [3:0] q, input logic tcu, input logic tcd);
      @(negedge CP);
      #1;
      PL = pl; D = d; UD = ud; CEP = cep; CET = cet;
      @(posedge CP);
      push(name, 1'b0, {4'h0, q}, tcu, tcd);
   endtask

   task automatic cstep(input string name, input logic pl, input logic [7:0] d,
                        input logic [7:0] q, input logic borrow);
      @(negedge CP);
      #1;
      c_pl = pl; c_d = d; c_ud = 1'b0; c_cep = 1'b1; c_cet = 1'b1;
      @(posedge CP);
      push(name, 1'b1, q, 1'b0, borrow);
   endtask

   exp_t       e_m;
   logic [7:0] act_q;
   logic       act_tcu;
   logic       act_tcd;

   always @(negedge CP) begin
      if (sbq.size() > 0) begin
         e_m = sbq.pop_front();
         if (e_m.casc) begin
            act_q   = {c_q1, c_q0};
            act_tcu = c_tcu1;
            act_tcd = c_tcd1;
         end else begin
            act_q   = {4'h0, Q};
            act_tcu = TCU;
            act_tcd = TCD;
         end
         n_chk++;
         if (act_q !== e_m.q || act_tcu !== e_m.tcu || act_tcd !== e_m.tcd) begin
            n_fail++;
            $display("FAIL %s: got q=%h tcu=%b tcd=%b, expected q=%h tcu=%b tcd=%b",
                     e_m.name, act_q, act_tcu, act_tcd, e_m.q, e_m.tcu, e_m.tcd);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      MR = 1'b1; PL = 1'b1; D = 4'h0; UD = 1'b0; CEP = 1'b1; CET = 1'b1;
      c_pl = 1'b1; c_d = 8'h00; c_ud = 1'b0; c_cep = 1'b0; c_cet = 1'b0;

      // Reset held with clocks running
      step("rst_hold0",   1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1);
      step("rst_load_ig", 1'b0, 4'hA, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1);
      step("rst_up_tc",   1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
      @(negedge CP);
      #1 MR = 1'b0;

      // Async reset pulse between edges while Q=9
      step("load9",       1'b0, 4'h9, 1'b0, 1'b1, 1'b1, 4'h9, 1'b0, 1'b0);
      step("hold9",       1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 4'h9, 1'b0, 1'b0);
      @(negedge CP);
      #1;
      @(posedge CP);
      #1 MR = 1'b1;
      #3 MR = 1'b0;
      push("async_rst", 1'b0, 8'h00, 1'b0, 1'b1);

      // Load then count down through zero
      step("load3",       1'b0, 4'h3, 1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
      step("dn2",         1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
      step("dn1",         1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
      step("dn0",         1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1);
      step("dnF",         1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
      step("dnE",         1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'hE, 1'b0, 1'b0);

      // Count up with wrap, then CET drop at max
      step("loadE",       1'b0, 4'hE, 1'b1, 1'b1, 1'b1, 4'hE, 1'b0, 1'b0);
      step("upF",         1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0);
      step("up0",         1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
      step("loadE_b",     1'b0, 4'hE, 1'b1, 1'b1, 1'b1, 4'hE, 1'b0, 1'b0);
      step("upF_b",       1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0);
      step("cet0_atF",    1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);

      // Enable holds
      step("up0_b",       1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         step("cep0_hold",  1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
      step("cet0_hold_d", 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      step("cet0_hold_u", 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

      // Load priority, max preset, direction flip
      step("load_wins",   1'b0, 4'h5, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0);
      step("loadF_tcu",   1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0);
      step("load6",       1'b0, 4'h6, 1'b1, 1'b1, 1'b1, 4'h6, 1'b0, 1'b0);
      step("up7",         1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0);
      step("flip_dn6",    1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'h6, 1'b0, 1'b0);

      // Two-stage down cascade
      cstep("c_load10",   1'b0, 8'h10, 8'h10, 1'b0);
      cstep("c_dn0F",     1'b1, 8'h00, 8'h0F, 1'b0);
      cstep("c_dn0E",     1'b1, 8'h00, 8'h0E, 1'b0);
      cstep("c_load01",   1'b0, 8'h01, 8'h01, 1'b0);
      cstep("c_dn00",     1'b1, 8'h00, 8'h00, 1'b1);
      cstep("c_dnFF",     1'b1, 8'h00, 8'hFF, 1'b0);

      for (int i = 0; i < 5 && sbq.size() > 0; i++)
         @(posedge CP);
      if (sbq.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, expected 0", sbq.size());
      end
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
